// File: rtl/elastic_pipe_queue.sv
// Elastic register pipeline with per-stage valid bits and valid/ready on both ends.
// Bubbles collapse under head backpressure; occupancy is tracked in a register.
module elastic_pipe_queue #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PIPE_DEPTH = 4,
    parameter int unsigned CNT_W      = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int H = PIPE_DEPTH - 1;

    logic [PIPE_DEPTH-1:0]                 vld_q, vld_d;
    logic [PIPE_DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]                      count_q, count_d;
    logic [PIPE_DEPTH-1:0]                 adv;
    logic                                  free0;
    logic                                  push, pop;

    // Walk from the head back to stage 0, carrying "next stage is free" as f.
    always_comb begin
        logic f;
        adv = '0;
        f   = 1'b0;
        for (int i = H; i >= 0; i--) begin
            adv[i] = vld_q[i] & ((i == H) ? ready_i : f);
            f      = ~vld_q[i] | adv[i];
        end
        free0 = f;
    end

    assign ready_o = free0 & ~flush_i & ~rst_i;
    assign push    = valid_i & ready_o;
    assign pop     = vld_q[H] & ready_i;

    always_comb begin
        vld_d   = vld_q;
        data_d  = data_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        vld_d[0] = push | (vld_q[0] & ~adv[0]);
        if (push) data_d[0] = data_i;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            vld_d[i] = adv[i-1] | (vld_q[i] & ~adv[i]);
            if (adv[i-1]) data_d[i] = data_q[i-1];
        end
        if (flush_i) begin
            vld_d   = '0;
            data_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign valid_o = vld_q[H];
    assign data_o  = data_q[H];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(PIPE_DEPTH));

endmodule

// File: tb/tb_elastic_pipe_queue.sv
// Directed table plus hand sequences for depth 4, and a scoreboarded random run at depth 1.
module tb_elastic_pipe_queue;

    typedef struct {
        logic       rst, flush, vin;
        logic [7:0] din;
        logic       rdy;
        logic       e_rdy, e_vld;
        logic [7:0] e_data;
        logic [2:0] e_cnt;
        logic       e_empty, e_full;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, flush;
    logic       vin, rdy, rdy_o, vld_o, empty_o, full_o;
    logic [7:0] din, dout;
    logic [2:0] cnt;
    logic       vin1, rdy1, rdy1_o, vld1_o, empty1_o, full1_o;
    logic [7:0] din1, dout1;
    logic [0:0] cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    elastic_pipe_queue #(.DATA_WIDTH(8), .PIPE_DEPTH(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin), .ready_o(rdy_o),
        .data_i(din), .valid_o(vld_o), .ready_i(rdy), .data_o(dout), .count_o(cnt),
        .empty_o(empty_o), .full_o(full_o)
    );

    elastic_pipe_queue #(.DATA_WIDTH(8), .PIPE_DEPTH(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vin1), .ready_o(rdy1_o),
        .data_i(din1), .valid_o(vld1_o), .ready_i(rdy1), .data_o(dout1), .count_o(cnt1),
        .empty_o(empty1_o), .full_o(full1_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v, input logic [7:0] d,
                         input logic rd);
        @(negedge clk);
        rst = r; flush = f; vin = v; din = d; rdy = rd;
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        // rst flush vin din rdy | rdy_o vld_o data cnt empty full
        vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 3'd0, 1, 0}); // in reset
        vecs.push_back('{0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 3'd0, 1, 0}); // after reset
        vecs.push_back('{0, 0, 1, 8'hA0, 0, 1, 0, 8'h00, 3'd0, 1, 0}); // fill under stall
        vecs.push_back('{0, 0, 1, 8'hA1, 0, 1, 0, 8'h00, 3'd1, 0, 0});
        vecs.push_back('{0, 0, 1, 8'hA2, 0, 1, 0, 8'h00, 3'd2, 0, 0});
        vecs.push_back('{0, 0, 1, 8'hA3, 0, 1, 0, 8'h00, 3'd3, 0, 0});
        vecs.push_back('{0, 0, 1, 8'hA4, 0, 0, 1, 8'hA0, 3'd4, 0, 1}); // full, stalled
        vecs.push_back('{0, 0, 1, 8'hA4, 0, 0, 1, 8'hA0, 3'd4, 0, 1});
        vecs.push_back('{0, 0, 1, 8'hA4, 1, 1, 1, 8'hA0, 3'd4, 0, 1}); // pop+push
        vecs.push_back('{0, 0, 1, 8'hA5, 1, 1, 1, 8'hA1, 3'd4, 0, 1});
        vecs.push_back('{0, 0, 0, 8'h00, 1, 1, 1, 8'hA2, 3'd4, 0, 1});
        vecs.push_back('{0, 0, 0, 8'h00, 1, 1, 1, 8'hA3, 3'd3, 0, 0});
        vecs.push_back('{0, 0, 1, 8'h33, 0, 1, 1, 8'hA4, 3'd2, 0, 0});
        vecs.push_back('{0, 1, 1, 8'h55, 0, 0, 1, 8'hA4, 3'd3, 0, 0}); // flush drops 0x55
        vecs.push_back('{0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 3'd0, 1, 0});
        vecs.push_back('{0, 0, 1, 8'hB0, 0, 1, 0, 8'h00, 3'd0, 1, 0});
        vecs.push_back('{0, 0, 1, 8'hB1, 0, 1, 0, 8'h00, 3'd1, 0, 0});
        vecs.push_back('{0, 0, 1, 8'hB2, 0, 1, 0, 8'h00, 3'd2, 0, 0});
        vecs.push_back('{0, 0, 1, 8'hB3, 0, 1, 0, 8'h00, 3'd3, 0, 0});
        vecs.push_back('{1, 0, 1, 8'hC0, 1, 0, 1, 8'hB0, 3'd4, 0, 1}); // reset while full
        vecs.push_back('{0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd0, 1, 0});
        vecs.push_back('{0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 3'd0, 1, 0});

        rst = 1'b1; flush = 1'b0; vin = 1'b0; din = '0; rdy = 1'b0;
        vin1 = 1'b0; din1 = '0; rdy1 = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].flush, vecs[k].vin, vecs[k].din, vecs[k].rdy);
            chk($sformatf("v%0d ready_o", k), 32'(rdy_o),   32'(vecs[k].e_rdy));
            chk($sformatf("v%0d valid_o", k), 32'(vld_o),   32'(vecs[k].e_vld));
            chk($sformatf("v%0d data_o", k),  32'(dout),    32'(vecs[k].e_data));
            chk($sformatf("v%0d count_o", k), 32'(cnt),     32'(vecs[k].e_cnt));
            chk($sformatf("v%0d empty_o", k), 32'(empty_o), 32'(vecs[k].e_empty));
            chk($sformatf("v%0d full_o", k),  32'(full_o),  32'(vecs[k].e_full));
        end

        // Streaming 0x01..0x10 with ready_i held high.
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b0, k < 16, 8'(k + 1), 1'b1);
            chk($sformatf("stream%0d ready_o", k), 32'(rdy_o), 32'd1);
            chk($sformatf("stream%0d valid_o", k), 32'(vld_o), 32'(k >= 4));
            if (k >= 4) chk($sformatf("stream%0d data_o", k), 32'(dout), 32'(k - 3));
            if (k >= 4 && k <= 16) chk($sformatf("stream%0d count_o", k), 32'(cnt), 32'd4);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("stream drained empty_o", 32'(empty_o), 32'd1);

        // Bubble collapse: 0x11, two idle cycles, 0x22, head stalled.
        drive(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("bubble count_o", 32'(cnt), 32'd2);
        chk("bubble ready_o", 32'(rdy_o), 32'd1);
        chk("bubble valid_o", 32'(vld_o), 32'd1);
        chk("bubble head0", 32'(dout), 32'h11);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("bubble adjacent valid_o", 32'(vld_o), 32'd1);
        chk("bubble head1", 32'(dout), 32'h22);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("bubble done empty_o", 32'(empty_o), 32'd1);

        // Depth 1 against a single-entry scoreboard.
        begin
            logic [7:0] sb[$];
            logic       exp_rdy;
            for (int k = 0; k < 10000; k++) begin
                @(negedge clk);
                vin1 = 1'($urandom_range(0, 1));
                din1 = 8'($urandom);
                rdy1 = 1'($urandom_range(0, 1));
                #1;
                exp_rdy = (sb.size() == 0) || rdy1;
                chk($sformatf("d1 c%0d ready_o", k), 32'(rdy1_o), 32'(exp_rdy));
                chk($sformatf("d1 c%0d valid_o", k), 32'(vld1_o), 32'(sb.size() == 1));
                chk($sformatf("d1 c%0d count_o", k), 32'(cnt1), 32'(sb.size()));
                if (sb.size() == 1) begin
                    chk($sformatf("d1 c%0d data_o", k), 32'(dout1), 32'(sb[0]));
                    if (rdy1) void'(sb.pop_front());
                end
                if (vin1 && exp_rdy) sb.push_back(din1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
